// File: rtl/aes_sched_if.sv
// Signal bundle between the requester fabric, the AES scheduler and the AES engine pins.
// The slave modport is the scheduler's view; master is the fabric/engine side.
interface aes_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_in;
    logic [2*NUM_REQ-1:0] mode_in;
    logic [NUM_REQ-1:0]   grant_out;
    logic [NUM_REQ-1:0]   done_out;
    logic [NUM_REQ-1:0]   timeout_out;
    logic [NUM_REQ-1:0]   err_out;
    logic [2:0]           aes_ctrl_out;
    logic                 aes_complete_in;
    logic                 busy_out;
    logic [IDX_W-1:0]     owner_out;

    modport master (
        output req_in,
        output mode_in,
        output aes_complete_in,
        input  grant_out,
        input  done_out,
        input  timeout_out,
        input  err_out,
        input  aes_ctrl_out,
        input  busy_out,
        input  owner_out
    );

    modport slave (
        input  req_in,
        input  mode_in,
        input  aes_complete_in,
        output grant_out,
        output done_out,
        output timeout_out,
        output err_out,
        output aes_ctrl_out,
        output busy_out,
        output owner_out
    );
endinterface

// File: rtl/aes_sched.sv
// Round-robin owner selection for the shared AES engine with watchdog, abort and a
// mandatory one-cycle control release between jobs so the engine clears its counters.
module aes_sched #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic       clk_in,
    input  logic       rst_in,
    aes_sched_if.slave io_sched
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_timeout;
    logic [NUM_REQ-1:0] r_err;
    logic [2:0]         r_ctrl;
    logic               r_busy;
    logic [IDX_W-1:0]   r_owner;
    logic [WD_W-1:0]    r_wdog;

    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic [NUM_REQ-1:0] w_timeout_nxt;
    logic [NUM_REQ-1:0] w_err_nxt;
    logic [2:0]         w_ctrl_nxt;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [WD_W-1:0]    w_wdog_nxt;

    logic               w_found;
    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_win_idx;
    logic [1:0]         w_win_mode;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [NUM_REQ-1:0] w_owner_onehot;

    // Index base+step wrapped modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin search from owner+1; a request with mode 00 is not a candidate.
    always_comb begin
        w_found    = 1'b0;
        w_cand     = '0;
        w_win_idx  = '0;
        w_win_mode = 2'b00;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = rr_idx(r_owner, k);
            if (!w_found && io_sched.req_in[w_cand] &&
                (io_sched.mode_in[{w_cand, 1'b0} +: 2] != 2'b00)) begin
                w_found    = 1'b1;
                w_win_idx  = w_cand;
                w_win_mode = io_sched.mode_in[{w_cand, 1'b0} +: 2];
            end else begin
                w_found    = w_found;
            end
        end
    end

    // One-hot decode of the arbitration winner and of the current owner.
    always_comb begin
        w_win_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
        w_owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    end

    // Next-state and next-output logic; every output is a register loaded from here.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_ctrl_nxt    = r_ctrl;
        w_owner_nxt   = r_owner;
        w_wdog_nxt    = r_wdog;
        w_done_nxt    = '0;
        w_timeout_nxt = '0;
        w_err_nxt     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_owner_nxt = w_win_idx;
                    if (w_win_mode == 2'b11) begin
                        w_err_nxt = w_win_onehot;
                    end else begin
                        w_grant_nxt = w_win_onehot;
                        w_ctrl_nxt  = {1'b0, w_win_mode};
                        w_wdog_nxt  = '0;
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_wdog_nxt = r_wdog + WD_W'(1);
                // Abort outranks completion, and completion outranks the watchdog.
                if (!io_sched.req_in[r_owner]) begin
                    w_grant_nxt = '0;
                    w_ctrl_nxt  = 3'b000;
                    w_state_nxt = ST_RELEASE;
                end else if (io_sched.aes_complete_in) begin
                    w_grant_nxt = '0;
                    w_ctrl_nxt  = 3'b000;
                    w_done_nxt  = w_owner_onehot;
                    w_state_nxt = ST_RELEASE;
                end else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    w_grant_nxt   = '0;
                    w_ctrl_nxt    = 3'b000;
                    w_timeout_nxt = w_owner_onehot;
                    w_state_nxt   = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RELEASE: begin
                w_grant_nxt = '0;
                w_ctrl_nxt  = 3'b000;
                w_wdog_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_ctrl_nxt  = 3'b000;
                w_wdog_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the owner on the last index so requester 0 wins first.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_done    <= '0;
            r_timeout <= '0;
            r_err     <= '0;
            r_ctrl    <= 3'b000;
            r_busy    <= 1'b0;
            r_owner   <= IDX_W'(NUM_REQ - 1);
            r_wdog    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_err     <= w_err_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_owner   <= w_owner_nxt;
            r_wdog    <= w_wdog_nxt;
        end
    end

    assign io_sched.grant_out    = r_grant;
    assign io_sched.done_out     = r_done;
    assign io_sched.timeout_out  = r_timeout;
    assign io_sched.err_out      = r_err;
    assign io_sched.aes_ctrl_out = r_ctrl;
    assign io_sched.busy_out     = r_busy;
    assign io_sched.owner_out    = r_owner;
endmodule
